// File: rtl/spi_pkg.sv
// Shared definitions for the 12-bit SPI link, used by both the responder and the master.
package spi_pkg;
  localparam int SPI_DATA_W = 12;

  // Mode 0 (CPOL=0, CPHA=0), least significant bit transmitted first.
  localparam logic [1:0] SPI_MODE      = 2'd0;
  localparam bit         SPI_LSB_FIRST = 1'b1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} spi_state_e;
endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with a selectable reset value.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= {STAGES{RST_VAL}};
    else      sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/spi_responder.sv
// Mode-0, LSB-first SPI responder oversampling sclk/cs/mosi on the system clock,
// with a one-entry tx buffer and a pulsed rx output.
module spi_responder
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              tx_underrun
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int SET_W = $clog2(SYNC_STAGES + 1);

  logic sclk_s, cs_s, mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk, .rst, .d_i(sclk), .q_o(sclk_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs   (.clk, .rst, .d_i(cs),   .q_o(cs_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk, .rst, .d_i(mosi), .q_o(mosi_s));

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  // Holds the first DATA_W-1 bits; the final bit is merged straight into rx_data.
  logic [DATA_W-2:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              underrun_q, underrun_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic              armed_q, armed_d;
  logic              sclk_prev_q, cs_prev_q;

  logic rise, fall, cs_fall;
  assign rise    = sclk_s & ~sclk_prev_q;
  assign fall    = ~sclk_s & sclk_prev_q;
  // Only a fall seen after cs has been observed high post-reset may start a frame.
  assign cs_fall = armed_q & cs_prev_q & ~cs_s;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    underrun_d  = 1'b0;
    settle_d    = settle_q;
    armed_d     = armed_q;

    if (settle_q != SET_W'(SYNC_STAGES)) settle_d = settle_q + SET_W'(1);
    else if (cs_s)                       armed_d  = 1'b1;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = SHIFT;
          cnt_d      = '0;
          tx_sr_d    = buf_full_q ? buf_q : '0;
          underrun_d = ~buf_full_q;
          buf_full_d = 1'b0;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (rise) begin
          cnt_d   = cnt_q + CNT_W'(1);
          rx_sr_d = {mosi_s, rx_sr_q[DATA_W-2:1]};
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d    = DONE;
            rx_data_d  = {mosi_s, rx_sr_q};
            rx_valid_d = 1'b1;
          end
        end else if (fall && cnt_q < CNT_W'(DATA_W)) begin
          tx_sr_d = tx_sr_q >> 1;
        end
      end
      DONE: begin
        if (cs_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Applied after the frame logic so a same-cycle start hands over the old word first.
    if (tx_valid && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      underrun_q  <= 1'b0;
      settle_q    <= '0;
      armed_q     <= 1'b0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      underrun_q  <= underrun_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign miso        = (state_q == SHIFT) ? tx_sr_q[0] : 1'b0;
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = (state_q != IDLE);
  assign frame_err   = frame_err_q;
  assign tx_underrun = underrun_q;
endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder: table vectors, hand-written corner sequences
// and randomized frames against a queue-based model of the tx buffer and rx word.
module tb_spi_responder;
  localparam int W    = 12;
  localparam int HALF = 11;

  logic         clk = 1'b0;
  logic         rst, sclk, cs, mosi, miso;
  logic [W-1:0] tx_data, rx_data;
  logic         tx_valid, tx_ready, rx_valid, busy, frame_err, tx_underrun;

  always #5 clk = ~clk;

  spi_responder #(.DATA_W(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .frame_err(frame_err), .tx_underrun(tx_underrun)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int rx_cnt = 0, fe_cnt = 0, ur_cnt = 0;

  // Pulse counters: each counts clock cycles the output is high.
  always @(negedge clk) begin
    if (rx_valid)    rx_cnt <= rx_cnt + 1;
    if (frame_err)   fe_cnt <= fe_cnt + 1;
    if (tx_underrun) ur_cnt <= ur_cnt + 1;
  end

  // Reference model: tx buffer as a queue of depth one, plus the last good rx word.
  logic [W-1:0] tx_model[$];
  logic [W-1:0] last_rx = '0;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else             n_pass++;
  endtask

  function automatic logic [W-1:0] low_mask(input int n);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < W; i++) if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  task automatic push_tx(input logic [W-1:0] w);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    if (tx_model.size() == 0) tx_model.push_back(w);
  endtask

  // Master side: mode 0, LSB first, miso captured at each sclk rise.
  task automatic spi_frame(input logic [W-1:0] w, input int nbits, input int half, input int tail,
                           output logic [W-1:0] got, output logic busy_seen);
    got  = '0;
    cs   = 1'b0;
    mosi = w[0];
    repeat (half) @(negedge clk);
    busy_seen = busy;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1;
      if (i < W) got[i] = miso;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
      if (i + 1 < W) mosi = w[i+1];
      repeat (half) @(negedge clk);
    end
    cs = 1'b1;
    repeat (tail) @(negedge clk);
  endtask

  task automatic frame_check(input string tag, input logic [W-1:0] w, input int nbits,
                             input int half, input int tail, input logic [W-1:0] exp_rx,
                             input logic [W-1:0] exp_miso, input int exp_ur);
    int           rx0, fe0, ur0;
    logic [W-1:0] got;
    logic         bs;
    bit           full;
    full = (nbits >= W);
    rx0 = rx_cnt; fe0 = fe_cnt; ur0 = ur_cnt;
    spi_frame(w, nbits, half, tail, got, bs);
    check({tag, "_busy_start"}, bs, 1);
    check({tag, "_rx_pulses"}, rx_cnt - rx0, full ? 1 : 0);
    check({tag, "_frame_err"}, fe_cnt - fe0, full ? 0 : 1);
    check({tag, "_underrun"}, ur_cnt - ur0, exp_ur);
    check({tag, "_rx_data"}, rx_data, exp_rx);
    check({tag, "_miso_word"}, got, exp_miso);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  task automatic model_frame(input string tag, input logic [W-1:0] w, input int nbits,
                             input int half);
    logic [W-1:0] exp_tx;
    int           exp_ur;
    if (tx_model.size() > 0) begin exp_tx = tx_model.pop_front(); exp_ur = 0; end
    else                     begin exp_tx = '0;                  exp_ur = 1; end
    if (nbits >= W) last_rx = w;
    frame_check(tag, w, nbits, half, 6, last_rx, exp_tx & low_mask(nbits), exp_ur);
    check({tag, "_tx_ready"}, tx_ready, (tx_model.size() == 0) ? 1 : 0);
  endtask

  typedef struct {
    logic         load;
    logic [W-1:0] tx_w;
    logic [W-1:0] mosi_w;
    int           nbits;
    logic [W-1:0] exp_rx;
    logic [W-1:0] exp_miso;
    int           exp_ur;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int rx0, ur0;

    vecs[0] = '{1'b1, 12'h3C5, 12'hA5C, 12, 12'hA5C, 12'h3C5, 0};
    vecs[1] = '{1'b0, 12'h000, 12'hFFF, 12, 12'hFFF, 12'h000, 1};
    vecs[2] = '{1'b0, 12'h000, 12'h0F0,  7, 12'hFFF, 12'h000, 1};  // cs lifted after 7 rises
    vecs[3] = '{1'b1, 12'h6B2, 12'h321, 14, 12'h321, 12'h6B2, 0};  // two extra edges in DONE

    rst = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_miso", miso, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_tx_underrun", tx_underrun, 0);
    rst = 1'b1;
    repeat (6) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].load) begin
        push_tx(vecs[i].tx_w);
        check($sformatf("vec%0d_tx_ready_full", i), tx_ready, 0);
      end
      if (tx_model.size() > 0) void'(tx_model.pop_front());
      if (vecs[i].nbits >= W) last_rx = vecs[i].mosi_w;
      frame_check($sformatf("vec%0d", i), vecs[i].mosi_w, vecs[i].nbits, HALF, 6,
                  vecs[i].exp_rx, vecs[i].exp_miso & low_mask(vecs[i].nbits), vecs[i].exp_ur);
    end

    // Second word offered while the buffer is full must be dropped.
    push_tx(12'h111);
    push_tx(12'h222);
    check("ovf_tx_ready", tx_ready, 0);
    void'(tx_model.pop_front());
    last_rx = 12'h0AA;
    frame_check("ovf", 12'h0AA, 12, HALF, 6, 12'h0AA, 12'h111, 0);

    // Back-to-back frames with only 4 clk of cs high in between.
    last_rx = 12'h001;
    frame_check("b2b_a", 12'h001, 12, HALF, 4, 12'h001, 12'h000, 1);
    last_rx = 12'h800;
    frame_check("b2b_b", 12'h800, 12, HALF, 6, 12'h800, 12'h000, 1);

    for (int i = 0; i < 24; i++) begin
      int nb, hp;
      if ($urandom_range(0, 1) == 1) push_tx(W'($urandom));
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 11)) : W;
      hp = $urandom_range(5, 11);
      model_frame($sformatf("rand%0d", i), W'($urandom), nb, hp);
    end

    // Reset in the middle of a frame, released while cs is still low.
    cs = 1'b0; mosi = 1'b1;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      sclk = 1'b1; repeat (HALF) @(negedge clk);
      sclk = 1'b0; mosi = 1'($urandom); repeat (HALF) @(negedge clk);
    end
    push_tx(12'h9C3);
    sclk = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_miso", miso, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_rx_data", rx_data, 0);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_frame_err", frame_err, 0);
    check("mid_rst_tx_underrun", tx_underrun, 0);
    tx_model.delete();
    last_rx = '0;
    @(negedge clk);
    rst = 1'b1;
    rx0 = rx_cnt; ur0 = ur_cnt;
    for (int i = 0; i < W; i++) begin
      sclk = 1'b0; repeat (HALF) @(negedge clk);
      sclk = 1'b1; repeat (HALF) @(negedge clk);
    end
    sclk = 1'b0;
    repeat (HALF) @(negedge clk);
    check("post_rst_no_busy", busy, 0);
    check("post_rst_no_rx", rx_cnt - rx0, 0);
    check("post_rst_no_start", ur_cnt - ur0, 0);
    check("post_rst_rx_data", rx_data, 0);
    cs = 1'b1;
    repeat (6) @(negedge clk);
    model_frame("post_rst", 12'h5A5, 12, HALF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/spi_responder.md
Name: spi_responder

Overview:
- SPI responder (slave end) for the 12-bit serial link.
- Runs entirely on the system clock and oversamples the serial pins through synchronizers.
- Full duplex: receives a word on mosi and returns a word on miso.
- The parallel side uses valid/ready handshakes on tx and a valid pulse on rx.

Parameters:
- DATA_W, 12: bits per frame.
- SYNC_STAGES, 2: synchronizer flops on sclk, cs and mosi. Minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset. 0 = reset asserted.
- sclk  input  1  serial clock from the master. Idles low.
- cs  input  1  chip select, active low.
- mosi  input  1  serial data from the master.
- miso  output  1  serial data to the master.
- tx_data  input  DATA_W  word to return in the next frame.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  tx buffer is empty and can accept a word.
- rx_data  output  DATA_W  last complete received word.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  a frame is in progress.
- frame_err  output  1  one-cycle pulse when cs deasserts before DATA_W bits.
- tx_underrun  output  1  one-cycle pulse when a frame starts with the tx buffer empty.

Behaviour:
- Reset values (rst=0, asynchronous): miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, frame_err=0, tx_underrun=0. State=IDLE, bit counter=0, tx buffer empty. Synchronizers reset cs to 1, sclk and mosi to 0.
- Mode 0 timing:
  - Master changes mosi on the sclk falling edge.
  - Responder samples mosi on the synchronized sclk rising edge.
  - Responder updates miso on the synchronized sclk falling edge.
- Bit order is LSB first in both directions.
- Edge detection: rise = sync_sclk & ~sclk_d; fall = ~sync_sclk & sclk_d. Edges are acted on only in SHIFT.
- Timing constraint: each sclk half-period must be at least SYNC_STAGES+2 clk cycles. A 11-clk half-period master is compliant.
- tx buffer (one entry):
  - tx_ready = buffer empty.
  - tx_valid & tx_ready loads tx_data; tx_ready falls on the next cycle.
  - tx_valid while tx_ready=0 is ignored and the buffer is not overwritten.
- State IDLE:
  - miso=0, busy=0.
  - On the synchronized cs falling edge, go to SHIFT and set busy=1.
  - tx shift register is loaded from the buffer (buffer then empty, tx_ready=1 next cycle). If the buffer is empty, load 0 and pulse tx_underrun.
  - miso = bit 0 of the loaded word in the same cycle the shift register loads.
  - Bit counter cleared.
  - If a handshake and frame start occur in the same cycle, the frame consumes the buffer's prior content. The new word is then written into the freed buffer.
- State SHIFT:
  - On rise: rx shift register = {sync_mosi, rx_sr[DATA_W-1:1]}, counter +1.
  - On fall: if the counter is below DATA_W, shift tx right and drive miso = next bit.
  - On the rise that makes the counter DATA_W: go to DONE. rx_data takes the completed word in the following cycle, with rx_valid=1 for exactly that cycle.
  - Latency: about SYNC_STAGES+2 clk from the physical 12th sclk rise to rx_valid.
- State DONE:
  - Further sclk edges are ignored; miso holds 0.
  - On cs high, go to IDLE and set busy=0.
  - One word per cs assertion.
- cs rising in SHIFT before DATA_W rises:
  - Pulse frame_err, discard the partial rx word, leave rx_data unchanged, no rx_valid.
  - Return to IDLE.
  - The consumed tx word is lost and is not restored.
- Reset in mid-frame: everything returns to reset values immediately. After reset release, a frame whose cs is already low is not started. A new cs falling edge is required.
- rx overwrite: a new rx_valid overwrites rx_data. There is no back-pressure on rx.

Decomposition:
- Shared package spi_pkg holds:
  - SPI_DATA_W = 12.
  - The state typedef: enum logic [1:0] {IDLE, SHIFT, DONE}.
  - The mode-0 / LSB-first constant.
  - The master uses the same package.
- One sub-module: spi_sync, a SYNC_STAGES-deep synchronizer with async active-low reset and a reset-value parameter. It is instantiated three times (sclk, cs, mosi).

Test Plan:
- Reset, then load tx=12'h3C5, then master sends 12'hA5C at 11-clk half-period → rx_valid pulses once, rx_data=12'hA5C, master captures 12'h3C5, tx_underrun=0.
- Frame with no tx loaded, mosi word 12'hFFF → tx_underrun pulses at cs fall, miso all 0, rx_data=12'hFFF.
- cs raised after 7 sclk rises with mosi word 12'h0F0 → frame_err pulses once, no rx_valid, rx_data keeps its previous value 12'hFFF, busy=0.
- tx_valid with 12'h111 then 12'h222 back-to-back while full → second word ignored (tx_ready=0), next frame returns 12'h111.
- Assert rst low at bit 5 of a frame, release while cs is still low → all outputs at reset values, no rx_valid until a fresh cs fall. The following frame 12'h5A5 is received correctly.
- Back-to-back frames 12'h001 and 12'h800, with cs high for 4 clk between them → two rx_valid pulses with the correct words. Extra sclk edges in DONE are ignored.
